// File: rtl/tdm_byte_tx.sv
// TDM serial byte transmitter: per-port FIFOs drained one byte per frame in slot order.
// The slot counter restarts on reset so it stays aligned with the switch's input-select counter.

module tdm_byte_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DW:0]              din,
   output logic [DW:0]              head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full
);
   localparam int AW = $clog2(DEPTH);

   logic [DW:0]   mem_q [DEPTH];
   logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [AW:0]   cnt_q, cnt_d;

   always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= din;
   end

   assign head  = mem_q[rd_q];
   assign count = cnt_q;
   assign full  = (cnt_q == (AW+1)'(DEPTH));
endmodule

module tdm_byte_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_QUEUES = 14,
   parameter int FIFO_DEPTH = 64,
   parameter int SLOT_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [7:0]            wr_port,
   input  logic                  wr_sop,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [NUM_QUEUES-1:0] wr_full,
   output logic [NUM_QUEUES-1:0] overflow,
   output logic [SLOT_WIDTH-1:0] slot,
   output logic                  tx_wire,
   output logic                  tx_new_packet,
   output logic [DATA_WIDTH-1:0] tx_data
);
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [SLOT_WIDTH-1:0] slot_q, slot_d;
   logic [NUM_QUEUES-1:0] push, pop, full, hit, ovf_q, ovf_d;
   logic [DATA_WIDTH:0]   head [NUM_QUEUES];
   logic [AW:0]           cnt  [NUM_QUEUES];
   logic                  wire_q, wire_d, np_q, np_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;

   assign slot_d = slot_q + 1'b1;

   for (genvar k = 0; k < NUM_QUEUES; k++) begin : g_port
      // Pop looks at pre-edge occupancy, so a same-edge push to an empty FIFO waits a frame.
      assign hit[k]   = rst && wr_en && (wr_port == 8'(k));
      assign pop[k]   = rst && (slot_d == SLOT_WIDTH'(k)) && (cnt[k] != '0);
      assign push[k]  = hit[k] && (!full[k] || pop[k]);
      assign ovf_d[k] = ovf_q[k] || (hit[k] && full[k] && !pop[k]);

      tdm_byte_fifo #(.DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (push[k]),
         .pop   (pop[k]),
         .din   ({wr_sop, wr_data}),
         .head  (head[k]),
         .count (cnt[k]),
         .full  (full[k])
      );
   end

   always_comb begin
      wire_d = 1'b0;
      np_d   = 1'b0;
      data_d = '0;
      for (int k = 0; k < NUM_QUEUES; k++) begin
         if (pop[k]) begin
            wire_d = 1'b1;
            np_d   = head[k][DATA_WIDTH];
            data_d = head[k][DATA_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         slot_q <= '0;
         wire_q <= 1'b0;
         np_q   <= 1'b0;
         data_q <= '0;
         ovf_q  <= '0;
      end else begin
         slot_q <= slot_d;
         wire_q <= wire_d;
         np_q   <= np_d;
         data_q <= data_d;
         ovf_q  <= ovf_d;
      end
   end

   assign slot          = slot_q;
   assign tx_wire       = wire_q;
   assign tx_new_packet = np_q;
   assign tx_data       = data_q;
   assign wr_full       = full;
   assign overflow      = ovf_q;
endmodule

// File: tb/tb_tdm_byte_tx.sv
// Randomized + directed bench; a queue-per-port reference model feeds a per-cycle scoreboard.
module tb_tdm_byte_tx;
   localparam int DW = 8, NQ = 14, DEPTH = 64, SW = 8;

   logic          clk = 0, rst = 0, wr_en = 0, wr_sop = 0;
   logic [7:0]    wr_port = 0;
   logic [DW-1:0] wr_data = 0;
   logic [NQ-1:0] wr_full, overflow;
   logic [SW-1:0] slot;
   logic          tx_wire, tx_new_packet;
   logic [DW-1:0] tx_data;

   tdm_byte_tx #(.DATA_WIDTH(DW), .NUM_QUEUES(NQ), .FIFO_DEPTH(DEPTH), .SLOT_WIDTH(SW)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_port(wr_port), .wr_sop(wr_sop),
      .wr_data(wr_data), .wr_full(wr_full), .overflow(overflow), .slot(slot),
      .tx_wire(tx_wire), .tx_new_packet(tx_new_packet), .tx_data(tx_data));

   always #5 clk = ~clk;

   typedef struct {
      logic          w, np;
      logic [DW-1:0] d;
      logic [SW-1:0] sl;
      logic [NQ-1:0] full, ovf;
   } exp_t;

   exp_t          sb[$];
   logic [DW:0]   mq [NQ][$];
   logic [NQ-1:0] m_ovf = '0;
   int            m_slot = 0, m_emit = 0, d_emit = 0;
   int            n_tests = 0, n_fail = 0, cyc = 0;

   // Reference: each edge pop slot s's queue head (if any), then apply the write.
   task automatic model_step();
      exp_t e;
      int   s;
      e.w = 0; e.np = 0; e.d = '0;
      if (!rst) begin
         for (int k = 0; k < NQ; k++) mq[k].delete();
         m_ovf  = '0;
         m_slot = 0;
      end else begin
         s = (m_slot + 1) % (1 << SW);
         if (s < NQ && mq[s].size() > 0) begin
            logic [DW:0] h;
            h = mq[s].pop_front();
            e.w = 1; e.np = h[DW]; e.d = h[DW-1:0];
            m_emit++;
         end
         if (wr_en && int'(wr_port) < NQ) begin
            if (mq[wr_port].size() < DEPTH) mq[wr_port].push_back({wr_sop, wr_data});
            else m_ovf[wr_port] = 1'b1;
         end
         m_slot = s;
      end
      e.sl = SW'(m_slot);
      e.ovf = m_ovf;
      for (int k = 0; k < NQ; k++) e.full[k] = (mq[k].size() == DEPTH);
      sb.push_back(e);
   endtask

   always @(posedge clk) begin
      cyc++;
      model_step();
   end

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         if (tx_wire === 1'b1) d_emit++;
         check("tx_wire", 32'(tx_wire), 32'(e.w));
         check("tx_new_packet", 32'(tx_new_packet), 32'(e.np));
         check("tx_data", 32'(tx_data), 32'(e.d));
         check("slot", 32'(slot), 32'(e.sl));
         check("wr_full", 32'(wr_full), 32'(e.full));
         check("overflow", 32'(overflow), 32'(e.ovf));
      end
   end

   task automatic idle(int n);
      wr_en = 0;
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(int p, logic sop, logic [DW-1:0] d);
      wr_en = 1; wr_port = 8'(p); wr_sop = sop; wr_data = d;
      @(negedge clk);
      wr_en = 0;
   endtask

   task automatic wait_slot(int v);
      int n = 0;
      wr_en = 0;
      while (m_slot != v && n < 600) begin
         @(negedge clk);
         n++;
      end
      if (m_slot != v) check("wait_slot_timeout", 32'(m_slot), 32'(v));
   endtask

   initial begin
      rst = 0;
      repeat (3) @(negedge clk);
      rst = 1;                                   // now in cycle with slot 0

      // Three-byte packet on port 2 written during slots 0..2.
      wr(2, 1, 8'hA1); wr(2, 0, 8'hA2); wr(2, 0, 8'hA3);
      idle(3 * 256 + 10);

      // One byte each on ports 0 and 13.
      wait_slot(20);
      wr(0, 1, 8'h10); wr(13, 1, 8'h1D);
      idle(300);

      // Overfill port 5 away from its slot, then let one byte drain.
      wait_slot(10);
      for (int i = 0; i < 65; i++) wr(5, i == 0, 8'(i));
      idle(260);

      // Out-of-range ports, then a push to empty port 4 on its own slot edge.
      wr(14, 1, 8'h55); wr(200, 1, 8'h66);
      wait_slot(3);
      wr(4, 1, 8'h44);
      idle(300);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         wr_en   = ($urandom_range(0, 3) != 0);
         wr_port = 8'($urandom_range(0, 15));
         wr_sop  = 1'($urandom);
         wr_data = 8'($urandom);
         @(negedge clk);
      end
      wr_en = 0;

      // Mid-operation reset with bytes queued on ports 3 and 9.
      wait_slot(10);
      for (int i = 0; i < 3; i++) begin wr(3, i == 0, 8'h30 + 8'(i)); wr(9, i == 0, 8'h90 + 8'(i)); end
      wait_slot(7);
      rst = 0;
      @(negedge clk);
      rst = 1;
      idle(600);

      check("emit_count", 32'(d_emit), 32'(m_emit));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
